// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA word pushes into a TX FIFO, STATUS word reports FIFO/shifter state.
// Define UART_TX_MMIO_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic        hit,
  output logic        txd,
  output logic        irq_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]   BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

`ifdef UART_TX_MMIO_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state;
  logic [15:0]   baud;
  logic [2:0]    bit_idx;
  logic [2:0]    next_idx;
  logic [7:0]    shifter;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] entries;
  logic          overflow;

  logic          full;
  logic          empty;
  logic          busy;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          status_wr;
  logic [6:0]    entries_ext;
  logic [3:0]    count_sat;
  logic [31:0]   status;
  logic          unused_data;

  assign hit       = (address[29:1] == BASE_ADDR[31:3]);
  assign push_req  = hit & wren & ~address[0];
  assign status_wr = hit & wren & address[0];

  assign full  = (entries == DEPTH_C);
  assign empty = (entries == '0);
  assign busy  = (state != IDLE);

  // A push against a full FIFO is dropped even when the shifter pops in the same cycle.
  assign push = push_req & ~full;
  assign pop  = (state == IDLE) & ~empty;

  assign irq_empty = empty & ~busy;

  assign entries_ext = 7'(entries);
  assign count_sat   = (entries_ext > 7'd15) ? 4'hF : entries_ext[3:0];
  assign status      = {24'b0, count_sat, overflow, busy, empty, full};

  assign next_idx    = bit_idx + 3'd1;
  assign unused_data = ^data[31:8];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      entries  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   entries <= entries + CW'(1);
        2'b01:   entries <= entries - CW'(1);
        default: entries <= entries;
      endcase
      if (push_req && full) begin
        overflow <= 1'b1;
      end else if (status_wr && data[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 32'h0;
    end else begin
      q <= (hit && address[0]) ? status : 32'h0;
    end
  end

  // txd is registered and updated on each state transition so it changes exactly at bit boundaries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      txd     <= 1'b1;
      baud    <= 16'h0;
      bit_idx <= 3'd0;
      shifter <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shifter <= mem[rd_ptr];
            state   <= START;
            baud    <= BAUD_RELOAD;
            txd     <= 1'b0;
          end
        end
        START: begin
          if (baud == 16'h0) begin
            state   <= DATA;
            baud    <= BAUD_RELOAD;
            bit_idx <= 3'd0;
            txd     <= shifter[0];
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud == 16'h0) begin
            baud    <= BAUD_RELOAD;
            bit_idx <= next_idx;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_MMIO_PARITY_EN
              state <= PARITY;
              txd   <= ^shifter;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shifter[next_idx];
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
`ifdef UART_TX_MMIO_PARITY_EN
        PARITY: begin
          if (baud == 16'h0) begin
            state <= STOP;
            baud  <= BAUD_RELOAD;
            txd   <= 1'b1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud == 16'h0) begin
            state <= IDLE;
            baud  <= BAUD_RELOAD;
            txd   <= 1'b1;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: bytes stored are queued and compared against frames decoded off txd.
module tb_uart_tx_mmio;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] BASE = 32'hFFFF_FFF0;
  localparam logic [29:0] DATA_ADDR   = {BASE[31:3], 1'b0};
  localparam logic [29:0] STATUS_ADDR = {BASE[31:3], 1'b1};
  localparam logic [29:0] IDLE_ADDR   = 30'h0000_0100;
`ifdef UART_TX_MMIO_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic        hit;
  logic        txd;
  logic        irq_empty;

  logic [7:0]  sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  uart_tx_mmio #(
    .CLK_DIV(CLK_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .data(data),
    .wren(wren),
    .q(q),
    .hit(hit),
    .txd(txd),
    .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [29:0] addr, input logic [31:0] wdata);
    address = addr;
    data    = wdata;
    wren    = 1'b1;
    @(posedge clk);
    #1;
    wren    = 1'b0;
    address = IDLE_ADDR;
    data    = 32'h0;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    if (accept) sb.push_back(b);
    bus_write(DATA_ADDR, {24'h0, b});
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    address = STATUS_ADDR;
    wren    = 1'b0;
    #1;
    check_output({tag, "_hit"}, {31'h0, hit}, 32'h1);
    @(posedge clk);
    #1;
    address = IDLE_ADDR;
    check_output(tag, q, exp);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!irq_empty && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (!irq_empty) check_output({tag, "_timeout"}, 32'h1, 32'h0);
  endtask

  // Frame decoder: every bit must hold for exactly CLK_DIV samples; a reset mid-frame discards it.
  initial begin : monitor
    logic [10:0] bits;
    logic [7:0]  rx;
    logic [7:0]  exp_b;
    bit          bit_err;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && txd === 1'b0) begin
        bits    = '0;
        bit_err = 1'b0;
        aborted = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
          for (int c = 0; c < CLK_DIV; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (reset_n !== 1'b1) aborted = 1'b1;
            else if (!aborted) begin
              if (c == 0) bits[b] = txd;
              else if (txd !== bits[b]) bit_err = 1'b1;
            end
          end
        end
        if (!aborted) begin
          rx = bits[8:1];
          check_output("bit_stable", {31'h0, bit_err}, 32'h0);
          check_output("stop_bit", {31'h0, bits[FRAME_BITS-1]}, 32'h1);
`ifdef UART_TX_MMIO_PARITY_EN
          check_output("parity_bit", {31'h0, bits[9]}, {31'h0, ^rx});
`endif
          if (sb.size() == 0) begin
            check_output("sb_underflow", {24'h0, rx}, 32'hFFFF_FFFF);
          end else begin
            exp_b = sb.pop_front();
            check_output("frame_byte", {24'h0, rx}, {24'h0, exp_b});
          end
        end
      end
    end
  end

  initial begin : stimulus
    int cycles;
    int lows;
    reset_n = 1'b0;
    address = IDLE_ADDR;
    data    = 32'h0;
    wren    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_txd", {31'h0, txd}, 32'h1);
    check_output("reset_q", q, 32'h0);
    check_output("reset_irq", {31'h0, irq_empty}, 32'h1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    read_status("status_reset", 32'h02);

    // Single frames: 0x55 alternating pattern, 0x07 exercises parity=1.
    write_byte(8'h55, 1'b1);
    wait_idle("frame55", 200, cycles);
    check_output("frame55_len", cycles, FRAME_CYCLES + 1);
    repeat (3) @(posedge clk);
    #1;
    write_byte(8'h07, 1'b1);
    wait_idle("frame07", 200, cycles);
    check_output("frame07_len", cycles, FRAME_CYCLES + 1);
    repeat (3) @(posedge clk);
    #1;

    // Fill: first byte goes straight to the shifter, next eight fill the FIFO, tenth overflows.
    for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i), 1'b1);
    write_byte(8'h19, 1'b0);
    read_status("status_full_ovf", 32'h8D);
    bus_write(STATUS_ADDR, 32'h8);
    read_status("status_ovf_clr", 32'h85);
    address = IDLE_ADDR;
    #1;
    check_output("outside_hit", {31'h0, hit}, 32'h0);
    @(posedge clk);
    #1;
    check_output("outside_q", q, 32'h0);
    read_status("status_unchanged", 32'h85);
    wait_idle("drain", 9 * (FRAME_CYCLES + 2) + 50, cycles);
    repeat (3) @(posedge clk);
    #1;
    check_output("sb_drained", sb.size(), 32'h0);
    read_status("status_drained", 32'h02);

    // Reset during data bit 3 of 0xA5 (bit value 0).
    write_byte(8'hA5, 1'b1);
    repeat (18) @(posedge clk);
    #1;
    check_output("pre_reset_bit3", {31'h0, txd}, 32'h0);
    reset_n = 1'b0;
    #1;
    check_output("abort_txd", {31'h0, txd}, 32'h1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    read_status("status_after_abort", 32'h02);
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check_output("line_quiet", lows, 32'h0);
    check_output("sb_final", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434: clk cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries; power of two, 2..64.
REQ-003 SHALL have parameter BASE_ADDR, default 32'hFFFF_FFF0: byte base address of the block; 8-byte aligned.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 address  input  30  word address (byte address [31:2]), same bus as RAM.
REQ-007 data  input  32  store data from the core.
REQ-008 wren  input  1  store strobe, valid for one clk.
REQ-009 q  output  32  registered read data.
REQ-010 hit  output  1  combinational decode: address[29:1] == BASE_ADDR[31:3].
REQ-011 txd  output  1  serial line, idle high.
REQ-012 irq_empty  output  1  high while FIFO empty and shifter idle.

Function
REQ-013 Word offset 0 (DATA): hit & wren & address[0]==0 SHALL push data[7:0] into the FIFO.
REQ-014 Word offset 1 (STATUS): q SHALL present {24'b0, count[3:0], overflow, busy, empty, full} one cycle after address is presented with hit=1.
REQ-015 count SHALL saturate at 15 in the STATUS field; full = (entries == FIFO_DEPTH); empty = (entries == 0).
REQ-016 When hit=0, q SHALL be 0 on the following cycle.
REQ-017 A push while full SHALL be dropped and SHALL set sticky overflow; a store to STATUS with data[3]=1 SHALL clear it.
REQ-018 Simultaneous push and pop while full SHALL drop the push; pop proceeds.
REQ-019 FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
REQ-020 IDLE with FIFO non-empty: pop head into shifter, go to START next cycle.
REQ-021 START: txd=0 for CLK_DIV cycles.
REQ-022 DATA: 8 bits, LSB first, each for CLK_DIV cycles; 3-bit index wraps 7->0 on exit.
REQ-023 STOP: txd=1 for CLK_DIV cycles, then IDLE; one IDLE cycle SHALL separate frames.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 Baud counter SHALL reload to CLK_DIV-1 on every state entry and count down to 0.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be FIFO_DEPTH+1 valued.

Reset
REQ-027 On reset_n low, asynchronously: FSM=IDLE, txd=1, FIFO empty, overflow=0, q=0, baud counter=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately; no partial byte is resumed.

Configuration
REQ-029 Macro UART_TX_MMIO_PARITY_EN defined: PARITY state between DATA and STOP drives even parity of the 8 data bits for CLK_DIV cycles; frame = 11 bit times.
REQ-030 Macro undefined: no PARITY state or logic; frame = 10 bit times (8N1).

Verification (CLK_DIV=4, FIFO_DEPTH=8)
REQ-031 Store 0x55 to DATA -> txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 each 4 cycles, high 4 cycles; total 40 cycles.
REQ-032 Nine stores back-to-back while idle -> first pops immediately, 8 held, no overflow; tenth store -> STATUS reads full=1, overflow=1.
REQ-033 Store to STATUS with data=0x8 -> next STATUS read has bit3=0, other bits unchanged.
REQ-034 Assert reset_n low during DATA bit 3 of 0xA5 -> txd=1 same cycle, STATUS=0x02 after release, no further line activity.
REQ-035 With UART_TX_MMIO_PARITY_EN, store 0x07 -> parity bit 1 after bit 7, frame 44 cycles; without it, store 0x07 -> 40-cycle frame.
REQ-036 Read with address outside BASE_ADDR window -> hit=0, q=0 next cycle, FIFO unchanged.
